// File: rtl/operand_fetch_pkg.sv
// Shared widths and helpers for the operand fetch stage and its scoreboard.
package operand_fetch_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_AW   = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;

    // Destination carried alongside the resolved operands.
    typedef struct packed {
        reg_addr_t rd_addr;
        logic      rd_we;
    } dest_t;

    // True when this cycle's writeback targets register r (x0 never matches).
    function automatic logic wb_hit(input logic wb_valid, input reg_addr_t wb_addr,
                                    input reg_addr_t r);
        return wb_valid && (wb_addr == r) && (r != '0);
    endfunction

endpackage

// File: rtl/operand_scoreboard.sv
// One pending bit per architectural register with same-cycle writeback bypass on lookup.
module operand_scoreboard
    import operand_fetch_pkg::*;
(
    input  logic      clock,
    input  logic      reset_n,
    input  logic      set_en,
    input  reg_addr_t set_addr,
    input  logic      clr_en,
    input  reg_addr_t clr_addr,
    input  logic      flush_clr_en,
    input  reg_addr_t flush_clr_addr,
    input  reg_addr_t rs1_addr,
    input  reg_addr_t rs2_addr,
    input  reg_addr_t rd_addr,
    output logic      busy_rs1,
    output logic      busy_rs2,
    output logic      busy_rd
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_next;

    // A register being written back this edge is no longer busy.
    assign busy_rs1 = pending[rs1_addr] && !(clr_en && (clr_addr == rs1_addr));
    assign busy_rs2 = pending[rs2_addr] && !(clr_en && (clr_addr == rs2_addr));
    assign busy_rd  = pending[rd_addr]  && !(clr_en && (clr_addr == rd_addr));

    // Clears first so a set to the same register in the same cycle wins.
    always_comb begin
        pending_next = pending;
        if (clr_en) begin
            pending_next[clr_addr] = 1'b0;
        end
        if (flush_clr_en) begin
            pending_next[flush_clr_addr] = 1'b0;
        end
        if (set_en) begin
            pending_next[set_addr] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: scoreboard hazard check, writeback bypass and a one-entry output slot.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int unsigned XLEN = operand_fetch_pkg::XLEN
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  reg_addr_t       in_rs1_addr,
    input  reg_addr_t       in_rs2_addr,
    input  reg_addr_t       in_rd_addr,
    input  logic            in_rd_we,
    output reg_addr_t       rf_rs1_addr,
    output reg_addr_t       rf_rs2_addr,
    input  logic [XLEN-1:0] rf_rs1_data,
    input  logic [XLEN-1:0] rf_rs2_data,
    input  logic            wb_valid,
    input  reg_addr_t       wb_rd_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output reg_addr_t       out_rd_addr,
    output logic            out_rd_we,
    output logic            stall
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]      state;
    logic [0:0]      state_next;
    logic            load;
    logic            busy_rs1;
    logic            busy_rs2;
    logic            busy_rd;
    logic            hazard;
    logic            accept;
    logic            set_en;
    logic            flush_clr_en;
    logic [XLEN-1:0] rs1_op;
    logic [XLEN-1:0] rs2_op;
    dest_t           slot_dest;

    assign rf_rs1_addr = in_rs1_addr;
    assign rf_rs2_addr = in_rs2_addr;

    assign hazard   = in_valid && (busy_rs1 || busy_rs2 || (in_rd_we && busy_rd));
    assign in_ready = reset_n && (!out_valid || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;
    assign stall    = in_valid && !in_ready;

    assign set_en       = accept && in_rd_we && (in_rd_addr != '0);
    assign flush_clr_en = flush && out_valid && out_rd_we && (out_rd_addr != '0);

    operand_scoreboard u_scoreboard (
        .clock          (clock),
        .reset_n        (reset_n),
        .set_en         (set_en),
        .set_addr       (in_rd_addr),
        .clr_en         (wb_valid),
        .clr_addr       (wb_rd_addr),
        .flush_clr_en   (flush_clr_en),
        .flush_clr_addr (out_rd_addr),
        .rs1_addr       (in_rs1_addr),
        .rs2_addr       (in_rs2_addr),
        .rd_addr        (in_rd_addr),
        .busy_rs1       (busy_rs1),
        .busy_rs2       (busy_rs2),
        .busy_rd        (busy_rd)
    );

    // Operand select: writeback bypass beats x0, which beats the register file.
    always_comb begin
        rs1_op = rf_rs1_data;
        rs2_op = rf_rs2_data;
        if (in_rs1_addr == '0) begin
            rs1_op = '0;
        end
        if (in_rs2_addr == '0) begin
            rs2_op = '0;
        end
        if (wb_hit(wb_valid, wb_rd_addr, in_rs1_addr)) begin
            rs1_op = wb_data;
        end
        if (wb_hit(wb_valid, wb_rd_addr, in_rs2_addr)) begin
            rs2_op = wb_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= S_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Output slot control; flush discards the held entry.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            S_EMPTY: begin
                if (accept) begin
                    state_next = S_FULL;
                    load       = 1'b1;
                end
            end
            S_FULL: begin
                if (flush) begin
                    state_next = S_EMPTY;
                end else if (out_ready) begin
                    if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_next = S_EMPTY;
                    end
                end
            end
            default: begin
                state_next = S_EMPTY;
            end
        endcase
    end

    assign out_valid   = (state == S_FULL);
    assign out_rd_addr = slot_dest.rd_addr;
    assign out_rd_we   = slot_dest.rd_we;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_rs1_data <= '0;
            out_rs2_data <= '0;
            slot_dest    <= '0;
        end else if (load) begin
            out_rs1_data <= rs1_op;
            out_rs2_data <= rs2_op;
            slot_dest    <= '{rd_addr: in_rd_addr, rd_we: in_rd_we};
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Cycle-stepped bench: vector table plus reset corner case, checked against a scoreboard model.
module tb_operand_fetch;

    localparam int unsigned XLEN = 32;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic            in_rd_we;
    logic [4:0]      rf_rs1_addr, rf_rs2_addr;
    logic [XLEN-1:0] rf_rs1_data, rf_rs2_data;
    logic            wb_valid;
    logic [4:0]      wb_rd_addr;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic            out_valid, out_ready;
    logic [XLEN-1:0] out_rs1_data, out_rs2_data;
    logic [4:0]      out_rd_addr;
    logic            out_rd_we;
    logic            stall;

    logic [XLEN-1:0] rf [32];

    always #5 clock = ~clock;

    assign rf_rs1_data = rf[rf_rs1_addr];
    assign rf_rs2_data = rf[rf_rs2_addr];

    operand_fetch #(.XLEN(XLEN)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rs1_addr  (in_rs1_addr),
        .in_rs2_addr  (in_rs2_addr),
        .in_rd_addr   (in_rd_addr),
        .in_rd_we     (in_rd_we),
        .rf_rs1_addr  (rf_rs1_addr),
        .rf_rs2_addr  (rf_rs2_addr),
        .rf_rs1_data  (rf_rs1_data),
        .rf_rs2_data  (rf_rs2_data),
        .wb_valid     (wb_valid),
        .wb_rd_addr   (wb_rd_addr),
        .wb_data      (wb_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rs1_data (out_rs1_data),
        .out_rs2_data (out_rs2_data),
        .out_rd_addr  (out_rd_addr),
        .out_rd_we    (out_rd_we),
        .stall        (stall)
    );

    typedef struct {
        logic            v;
        logic [4:0]      rs1, rs2, rd;
        logic            we;
        logic            wbv;
        logic [4:0]      wbrd;
        logic [XLEN-1:0] wbd;
        logic            ordy;
        logic            fl;
        logic            exp_rdy;
    } vec_t;

    typedef struct {
        logic [XLEN-1:0] rs1_data, rs2_data;
        logic [4:0]      rd;
        logic            we;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_pending;
    logic        m_full;
    int          total;
    int          bad;
    vec_t        vecs [27];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic we, input logic wbv,
                                input logic [4:0] wbrd, input logic [XLEN-1:0] wbd,
                                input logic ordy, input logic fl, input logic exp_rdy);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.we = we;
        t.wbv = wbv; t.wbrd = wbrd; t.wbd = wbd; t.ordy = ordy; t.fl = fl;
        t.exp_rdy = exp_rdy;
        return t;
    endfunction

    function automatic logic [XLEN-1:0] exp_opnd(input logic [4:0] rs, input logic wbv,
                                                 input logic [4:0] wbrd,
                                                 input logic [XLEN-1:0] wbd);
        if (wbv && wbrd == rs && rs != 5'd0) return wbd;
        if (rs == 5'd0) return '0;
        return rf[rs];
    endfunction

    // One clock cycle: drive at negedge, check just before posedge, advance the model.
    task automatic step(input vec_t t, input logic rst);
        logic        busy1, busy2, busyd, m_rdy, acc;
        logic [31:0] nxt;
        exp_t        e;
        reset_n     = !rst;
        in_valid    = t.v;
        in_rs1_addr = t.rs1;
        in_rs2_addr = t.rs2;
        in_rd_addr  = t.rd;
        in_rd_we    = t.we;
        wb_valid    = t.wbv;
        wb_rd_addr  = t.wbrd;
        wb_data     = t.wbd;
        out_ready   = t.ordy;
        flush       = t.fl;
        #4;
        busy1 = m_pending[t.rs1] && !(t.wbv && t.wbrd == t.rs1);
        busy2 = m_pending[t.rs2] && !(t.wbv && t.wbrd == t.rs2);
        busyd = m_pending[t.rd]  && !(t.wbv && t.wbrd == t.rd);
        m_rdy = !rst && (!m_full || t.ordy) && !t.fl
                && !(t.v && (busy1 || busy2 || (t.we && busyd)));
        acc   = t.v && m_rdy;
        chk("in_ready_vec", in_ready, t.exp_rdy);
        chk("in_ready_model", in_ready, m_rdy);
        chk("stall", stall, t.v && !m_rdy);
        chk("out_valid", out_valid, m_full);
        chk("pending", dut.u_scoreboard.pending, m_pending);
        if (m_full && exp_q.size() > 0) begin
            chk("out_rs1_data", out_rs1_data, exp_q[0].rs1_data);
            chk("out_rs2_data", out_rs2_data, exp_q[0].rs2_data);
            chk("out_rd_addr", out_rd_addr, exp_q[0].rd);
            chk("out_rd_we", out_rd_we, exp_q[0].we);
        end
        e.rs1_data = exp_opnd(t.rs1, t.wbv, t.wbrd, t.wbd);
        e.rs2_data = exp_opnd(t.rs2, t.wbv, t.wbrd, t.wbd);
        e.rd       = t.rd;
        e.we       = t.we;
        nxt = m_pending;
        if (rst) begin
            nxt = '0;
            m_full = 1'b0;
            exp_q.delete();
        end else begin
            if (t.wbv) nxt[t.wbrd] = 1'b0;
            if (t.fl && m_full) begin
                if (exp_q[0].we && exp_q[0].rd != 5'd0) nxt[exp_q[0].rd] = 1'b0;
                void'(exp_q.pop_front());
                m_full = 1'b0;
            end else if (m_full && t.ordy) begin
                void'(exp_q.pop_front());
                m_full = 1'b0;
            end
            if (acc) begin
                exp_q.push_back(e);
                m_full = 1'b1;
                if (t.we && t.rd != 5'd0) nxt[t.rd] = 1'b1;
            end
        end
        nxt[0] = 1'b0;
        @(posedge clock);
        @(negedge clock);
        m_pending = nxt;
        if (t.wbv && t.wbrd != 5'd0) rf[t.wbrd] = t.wbd;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + 32'(i);
        rf[1]     = 32'd5;
        m_pending = '0;
        m_full    = 1'b0;

        // independent op, RAW, WAW, backpressure, flush, x0 destination, bypass
        vecs[0]  = mk(1, 1, 0, 2,  0, 0, 0,  0,     1, 0, 1);
        vecs[1]  = mk(0, 0, 0, 0,  0, 0, 0,  0,     1, 0, 1);
        vecs[2]  = mk(1, 0, 0, 3,  1, 0, 0,  0,     1, 0, 1);
        vecs[3]  = mk(1, 3, 0, 6,  0, 0, 0,  0,     1, 0, 0);
        vecs[4]  = mk(1, 3, 0, 6,  0, 0, 0,  0,     1, 0, 0);
        vecs[5]  = mk(1, 3, 0, 6,  0, 1, 3,  'hAA,  1, 0, 1);
        vecs[6]  = mk(0, 0, 0, 0,  0, 0, 0,  0,     1, 0, 1);
        vecs[7]  = mk(1, 0, 0, 4,  1, 0, 0,  0,     1, 0, 1);
        vecs[8]  = mk(1, 0, 0, 4,  1, 0, 0,  0,     1, 0, 0);
        vecs[9]  = mk(1, 0, 0, 4,  1, 1, 4,  'h44,  1, 0, 1);
        vecs[10] = mk(0, 0, 0, 0,  0, 0, 0,  0,     1, 0, 1);
        vecs[11] = mk(0, 0, 0, 0,  0, 1, 4,  'h55,  1, 0, 1);
        vecs[12] = mk(1, 1, 2, 8,  0, 0, 0,  0,     1, 0, 1);
        vecs[13] = mk(1, 2, 1, 9,  0, 0, 0,  0,     0, 0, 0);
        vecs[14] = mk(1, 2, 1, 9,  0, 0, 0,  0,     0, 0, 0);
        vecs[15] = mk(1, 2, 1, 9,  0, 0, 0,  0,     0, 0, 0);
        vecs[16] = mk(1, 2, 1, 9,  0, 0, 0,  0,     1, 0, 1);
        vecs[17] = mk(0, 0, 0, 0,  0, 0, 0,  0,     1, 0, 1);
        vecs[18] = mk(1, 0, 0, 7,  1, 0, 0,  0,     1, 0, 1);
        vecs[19] = mk(0, 0, 0, 0,  0, 0, 0,  0,     0, 0, 0);
        vecs[20] = mk(1, 1, 0, 10, 0, 0, 0,  0,     0, 1, 0);
        vecs[21] = mk(0, 0, 0, 0,  0, 0, 0,  0,     1, 0, 1);
        vecs[22] = mk(1, 0, 0, 0,  1, 0, 0,  0,     1, 0, 1);
        vecs[23] = mk(1, 0, 0, 0,  1, 0, 0,  0,     1, 0, 1);
        vecs[24] = mk(0, 0, 0, 0,  0, 1, 12, 'h77,  1, 0, 1);
        vecs[25] = mk(1, 0, 12, 13, 0, 1, 12, 'h99, 1, 0, 1);
        vecs[26] = mk(0, 0, 0, 0,  0, 0, 0,  0,     1, 0, 1);

        reset_n = 1'b0; in_valid = 1'b0; in_rs1_addr = '0; in_rs2_addr = '0;
        in_rd_addr = '0; in_rd_we = 1'b0; wb_valid = 1'b0; wb_rd_addr = '0;
        wb_data = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_rs1", out_rs1_data, 0);
        chk("rst_out_rd", {out_rd_addr, out_rd_we}, 0);
        chk("rst_pending", dut.u_scoreboard.pending, 0);

        for (int i = 0; i < 27; i++) step(vecs[i], 1'b0);

        // Reset while stalled on pending x5 with the slot held full.
        step(mk(1, 0, 0, 5,  1, 0, 0, 0, 1, 0, 1), 1'b0);
        step(mk(1, 5, 0, 11, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        step(mk(1, 5, 0, 11, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_data", {out_rs1_data, out_rs2_data}, 0);
        chk("midrst_out_rd", {out_rd_addr, out_rd_we}, 0);
        step(mk(1, 5, 0, 11, 0, 0, 0, 0, 1, 0, 1), 1'b0);
        step(mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 1), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
